muldiv_sequencer: RTL

Multi-cycle M-extension sequencer in the EX pipe stage. Accepts MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operations decoded by EX control, runs them on an iterative shift-add / restoring-divide datapath, and stalls the pipeline until the result is ready. Single-cycle ALU ops bypass this block entirely.

---
 rtl/muldiv_sequencer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer for the EX stage: shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN to finish multiplies in one cycle; M-op codes are 5'b10_fff with fff = RV funct3.
module muldiv_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  ALUOp,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

    localparam logic [2:0] F_MUL    = 3'd0;
    localparam logic [2:0] F_MULH   = 3'd1;
    localparam logic [2:0] F_MULHSU = 3'd2;
    localparam logic [2:0] F_MULHU  = 3'd3;
    localparam logic [2:0] F_DIV    = 3'd4;
    localparam logic [2:0] F_DIVU   = 3'd5;
    localparam logic [2:0] F_REM    = 3'd6;
    localparam logic [2:0] F_REMU   = 3'd7;

    function automatic logic [31:0] cond_neg32(input logic neg, input logic [31:0] v);
        cond_neg32 = neg ? (32'd0 - v) : v;
    endfunction

    function automatic logic [63:0] cond_neg64(input logic neg, input logic [63:0] v);
        cond_neg64 = neg ? (64'd0 - v) : v;
    endfunction

    state_e      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [2:0]  fn_q, fn_d;
    logic        neg_q, neg_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;

    logic        is_m_s, sa_s, sb_s, sign_a_s, sign_b_s, div0_s, ovf_s, fast_hit_s, borrow_s;
    logic [2:0]  fn_s;
    logic [31:0] abs_a_s, abs_b_s, early_res_s, fast_res_s, rem_nx_s, quo_nx_s, run_res_s;
    logic [32:0] rem_sh_s;
    logic [63:0] mul_acc_s, prod_s;

    // Operand decode, sign handling and early-out detection for an incoming op
    always_comb begin
        is_m_s   = (ALUOp[4:3] == 2'b10);
        fn_s     = ALUOp[2:0];
        case (fn_s)
            F_MUL, F_MULH, F_DIV, F_REM: begin sa_s = 1'b1; sb_s = 1'b1; end
            F_MULHSU:                    begin sa_s = 1'b1; sb_s = 1'b0; end
            default:                     begin sa_s = 1'b0; sb_s = 1'b0; end
        endcase
        sign_a_s = sa_s & op_a[31];
        sign_b_s = sb_s & op_b[31];
        abs_a_s  = cond_neg32(sign_a_s, op_a);
        abs_b_s  = cond_neg32(sign_b_s, op_b);
        div0_s   = fn_s[2] & (op_b == 32'd0);
        ovf_s    = ((fn_s == F_DIV) || (fn_s == F_REM)) &&
                   (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
        // fn[1] separates REM/REMU from DIV/DIVU
        if (div0_s) begin
            early_res_s = fn_s[1] ? op_a : 32'hFFFF_FFFF;
        end else begin
            early_res_s = fn_s[1] ? 32'd0 : 32'h8000_0000;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] ext_a_s, ext_b_s, fprod_s;

    // Single-cycle multiply on sign-extended operands; low 64 bits of the 33x33 product
    always_comb begin
        ext_a_s    = {{32{sign_a_s}}, op_a};
        ext_b_s    = {{32{sign_b_s}}, op_b};
        fprod_s    = ext_a_s * ext_b_s;
        fast_hit_s = ~fn_s[2];
        fast_res_s = (fn_s == F_MUL) ? fprod_s[31:0] : fprod_s[63:32];
    end
`else
    // Multiplies always take the iterative path in this build
    always_comb begin
        fast_hit_s = 1'b0;
        fast_res_s = 32'd0;
    end
`endif

    // One datapath iteration plus the final sign fix-up and output select
    always_comb begin
        mul_acc_s = acc_q + (mplier_q[count_q] ? mcand_q : 64'd0);
        rem_sh_s  = {acc_q[31:0], mcand_q[31]};
        borrow_s  = (rem_sh_s < {1'b0, mplier_q});
        rem_nx_s  = borrow_s ? rem_sh_s[31:0] : (rem_sh_s[31:0] - mplier_q);
        quo_nx_s  = {mcand_q[30:0], ~borrow_s};
        prod_s    = cond_neg64(neg_q, mul_acc_s);
        case (fn_q)
            F_MUL:                     run_res_s = prod_s[31:0];
            F_MULH, F_MULHSU, F_MULHU: run_res_s = prod_s[63:32];
            F_DIV, F_DIVU:             run_res_s = cond_neg32(neg_q, quo_nx_s);
            F_REM, F_REMU:             run_res_s = cond_neg32(neg_q, rem_nx_s);
            default:                   run_res_s = 32'd0;
        endcase
    end

    // Next-state logic for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        fn_d     = fn_q;
        neg_d    = neg_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start && is_m_s && !flush) begin
                    fn_d     = fn_s;
                    neg_d    = fn_s[2] && fn_s[1] ? sign_a_s : (sign_a_s ^ sign_b_s);
                    count_d  = 5'd0;
                    acc_d    = 64'd0;
                    mcand_d  = {32'd0, abs_a_s};
                    mplier_d = abs_b_s;
                    if (div0_s || ovf_s) begin
                        result_d = early_res_s;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else if (fast_hit_s) begin
                        result_d = fast_res_s;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d  = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                count_d = count_q + 5'd1;
                if (fn_q[2]) begin
                    acc_d   = {32'd0, rem_nx_s};
                    mcand_d = {32'd0, quo_nx_s};
                end else begin
                    acc_d   = mul_acc_s;
                    mcand_d = {mcand_q[62:0], 1'b0};
                end
                if (flush) begin
                    state_d = IDLE;
                end else if (count_q == 5'd31) begin
                    result_d = run_res_s;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pipeline hold: accepted start cycle plus every RUN cycle
    always_comb begin
        if (reset) begin
            stall = 1'b0;
        end else begin
            stall = ((state_q == IDLE) && start && is_m_s && !flush) || (state_q == RUN);
        end
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= 5'd0;
            acc_q    <= 64'd0;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            fn_q     <= 3'd0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            fn_q     <= fn_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule
